// File: rtl/regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl
// Write-side controller for the integer register file. Single-cycle ALU
// results and variable-latency load responses share one register-file write
// port. Load responses wait in a small circular FIFO. The ALU always has
// priority over the FIFO. A pending scoreboard tracks registers that still
// have a load in flight, so decode can stall on read-after-write hazards.
//
// Ports
//   clk                      : rising-edge clock
//   rst                      : asynchronous, active-low reset
//   alu_valid/alu_rd/alu_data: ALU result (no backpressure)
//   ld_valid/ld_ready        : load-response handshake
//   ld_rd/ld_data            : load destination and data
//   issue_valid/issue_rd     : load issue (sets the pending bit)
//   rs1_index/rs2_index      : decode read indices
//   rs1_pending/rs2_pending  : indexed register has a load outstanding
//   wb_en/rd_index/wb_data   : registered register-file write port
//   fifo_count               : load FIFO occupancy
// ---------------------------------------------------------------------------
module regfile_wb_ctrl #(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alu_valid,
   input  logic [4:0]                 alu_rd,
   input  logic [31:0]                alu_data,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [4:0]                 ld_rd,
   input  logic [31:0]                ld_data,
   input  logic                       issue_valid,
   input  logic [4:0]                 issue_rd,
   input  logic [4:0]                 rs1_index,
   input  logic [4:0]                 rs2_index,
   output logic                       rs1_pending,
   output logic                       rs2_pending,
   output logic                       wb_en,
   output logic [4:0]                 rd_index,
   output logic [31:0]                wb_data,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   // FIFO storage and pointers; pointers wrap naturally because DEPTH is a power of two
   logic [4:0]    mem_rd_r   [DEPTH];
   logic [31:0]   mem_data_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;

   // Cleared by reset, set on the first edge afterwards: keeps ld_ready low in reset
   logic          ready_en_r;

   logic [31:0]   pending_r;
   logic          wb_en_r;
   logic [4:0]    rd_index_r;
   logic [31:0]   wb_data_r;

   logic          alu_sel_s;
   logic          pop_s;
   logic          accept_s;
   logic          push_s;
   logic [4:0]    head_rd_s;
   logic [31:0]   head_data_s;
   logic [CW-1:0] count_nxt_s;
   logic [31:0]   clr_mask_s;
   logic [31:0]   set_mask_s;
   logic [31:0]   pending_nxt_s;

   // ld_ready looks only at the registered count, so a full FIFO never accepts
   // even when it pops in the same cycle.
   assign ld_ready    = ready_en_r && (count_r < FULL_C);
   assign fifo_count  = count_r;
   assign wb_en       = wb_en_r;
   assign rd_index    = rd_index_r;
   assign wb_data     = wb_data_r;
   assign rs1_pending = pending_r[rs1_index];
   assign rs2_pending = pending_r[rs2_index];

   // Write-port selection, FIFO push/pop, and next occupancy
   always_comb begin
      alu_sel_s   = 1'b0;
      pop_s       = 1'b0;
      accept_s    = 1'b0;
      push_s      = 1'b0;
      head_rd_s   = mem_rd_r[rd_ptr_r];
      head_data_s = mem_data_r[rd_ptr_r];
      count_nxt_s = count_r;

      // An ALU write to x0 is dropped, which leaves the port free for the FIFO
      alu_sel_s = alu_valid && (alu_rd != 5'd0);
      pop_s     = !alu_sel_s && (count_r != {CW{1'b0}});
      accept_s  = ld_valid && ld_ready;
      // A load to x0 completes its handshake but is never stored
      push_s    = accept_s && (ld_rd != 5'd0);

      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pending scoreboard update: a clear from the popped head, then a set from issue (set wins)
   always_comb begin
      clr_mask_s    = 32'd0;
      set_mask_s    = 32'd0;
      pending_nxt_s = pending_r;

      if (pop_s) begin
         clr_mask_s = 32'd1 << head_rd_s;
      end else begin
         clr_mask_s = 32'd0;
      end

      if (issue_valid && (issue_rd != 5'd0)) begin
         set_mask_s = 32'd1 << issue_rd;
      end else begin
         set_mask_s = 32'd0;
      end

      pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
   end

   // FIFO pointers, occupancy and ready-enable flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         ready_en_r <= 1'b0;
      end else begin
         ready_en_r <= 1'b1;
         count_r    <= count_nxt_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

   // FIFO storage; cleared in reset so no stale entry can leak out afterwards
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_rd_r[i]   <= 5'd0;
            mem_data_r[i] <= 32'd0;
         end
      end else if (push_s) begin
         mem_rd_r[wr_ptr_r]   <= ld_rd;
         mem_data_r[wr_ptr_r] <= ld_data;
      end else begin
         mem_rd_r[wr_ptr_r]   <= mem_rd_r[wr_ptr_r];
         mem_data_r[wr_ptr_r] <= mem_data_r[wr_ptr_r];
      end
   end

   // Pending scoreboard register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_r <= 32'd0;
      end else begin
         pending_r <= pending_nxt_s;
      end
   end

   // Registered write port; index and data hold their value when idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en_r    <= 1'b0;
         rd_index_r <= 5'd0;
         wb_data_r  <= 32'd0;
      end else if (alu_sel_s) begin
         wb_en_r    <= 1'b1;
         rd_index_r <= alu_rd;
         wb_data_r  <= alu_data;
      end else if (pop_s) begin
         wb_en_r    <= 1'b1;
         rd_index_r <= head_rd_s;
         wb_data_r  <= head_data_s;
      end else begin
         wb_en_r    <= 1'b0;
         rd_index_r <= rd_index_r;
         wb_data_r  <= wb_data_r;
      end
   end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_ctrl
// Scoreboard bench for regfile_wb_ctrl. The driver applies stimulus and runs
// a queue-based reference model. After each clock edge it pushes the expected
// post-edge state into exp_q. A monitor on the falling edge pops the entries
// and compares them. Directed scenarios also check fixed expected values.
// ---------------------------------------------------------------------------
module tb_regfile_wb_ctrl;

   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid;
   logic [4:0]    alu_rd;
   logic [31:0]   alu_data;
   logic          ld_valid;
   logic          ld_ready;
   logic [4:0]    ld_rd;
   logic [31:0]   ld_data;
   logic          issue_valid;
   logic [4:0]    issue_rd;
   logic [4:0]    rs1_index;
   logic [4:0]    rs2_index;
   logic          rs1_pending;
   logic          rs2_pending;
   logic          wb_en;
   logic [4:0]    rd_index;
   logic [31:0]   wb_data;
   logic [CW-1:0] fifo_count;

   regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1_index(rs1_index), .rs2_index(rs2_index),
      .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
      .wb_en(wb_en), .rd_index(rd_index), .wb_data(wb_data),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ld_t;

   typedef struct {
      logic        wb;
      logic [4:0]  rd;
      logic [31:0] data;
      int          cnt;
      logic        rdy;
      logic [31:0] pend;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // reference model state
   ld_t         m_q[$];
   logic [31:0] m_pend = 32'd0;
   logic        m_wb   = 1'b0;
   logic [4:0]  m_rd   = 5'd0;
   logic [31:0] m_data = 32'd0;
   logic        m_run  = 1'b0;
   logic        m_acc  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock: model the edge from the current inputs, then queue the expectation
   task automatic step();
      exp_t e;
      ld_t  ent;
      if (!rst) begin
         m_q.delete();
         m_pend = 32'd0;
         m_wb   = 1'b0;
         m_rd   = 5'd0;
         m_data = 32'd0;
         m_run  = 1'b0;
         m_acc  = 1'b0;
      end else begin
         m_acc = ld_valid && m_run && (m_q.size() < DEPTH);
         if (alu_valid && alu_rd != 5'd0) begin
            m_wb = 1'b1; m_rd = alu_rd; m_data = alu_data;
         end else if (m_q.size() > 0) begin
            ent = m_q.pop_front();
            m_wb = 1'b1; m_rd = ent.rd; m_data = ent.data;
            m_pend[ent.rd] = 1'b0;
         end else begin
            m_wb = 1'b0;
         end
         if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
         if (m_acc && ld_rd != 5'd0) begin
            ent.rd = ld_rd; ent.data = ld_data;
            m_q.push_back(ent);
         end
         m_run = 1'b1;
      end
      e.wb = m_wb; e.rd = m_rd; e.data = m_data; e.cnt = m_q.size();
      e.rdy = m_run && (m_q.size() < DEPTH); e.pend = m_pend;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0;
   endtask

   // Monitor: compare DUT against the queued expectation on every falling edge
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_wb_en", {31'd0, wb_en}, {31'd0, e.wb});
         chk("sb_rd_index", {27'd0, rd_index}, {27'd0, e.rd});
         chk("sb_wb_data", wb_data, e.data);
         chk("sb_fifo_count", 32'(fifo_count), 32'(e.cnt));
         chk("sb_ld_ready", {31'd0, ld_ready}, {31'd0, e.rdy});
         chk("sb_rs1_pending", {31'd0, rs1_pending}, {31'd0, e.pend[rs1_index]});
         chk("sb_rs2_pending", {31'd0, rs2_pending}, {31'd0, e.pend[rs2_index]});
         chk("sb_no_x0_write", {31'd0, (wb_en && rd_index == 5'd0)}, 32'd0);
      end
   end

   initial begin
      int li;
      rst = 1'b1;
      idle();
      alu_rd = 5'd0; alu_data = 32'd0; ld_rd = 5'd0; ld_data = 32'd0;
      issue_rd = 5'd0; rs1_index = 5'd0; rs2_index = 5'd0;
      #2 rst = 1'b0;
      #1;
      chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
      chk("rst_rd_index", {27'd0, rd_index}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      step(); step();
      rst = 1'b1;
      step();
      chk("ready_after_reset", {31'd0, ld_ready}, 32'd1);

      // basic ALU write
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      step();
      chk("alu_wb_en", {31'd0, wb_en}, 32'd1);
      chk("alu_rd_index", {27'd0, rd_index}, 32'd5);
      chk("alu_wb_data", wb_data, 32'hDEADBEEF);
      idle();
      step();
      chk("alu_wb_en_off", {31'd0, wb_en}, 32'd0);

      // load path and scoreboard
      issue_valid = 1'b1; issue_rd = 5'd7; rs1_index = 5'd7;
      step();
      chk("ld_pending_set", {31'd0, rs1_pending}, 32'd1);
      idle();
      step();
      ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
      step();
      idle();
      chk("ld_count1", 32'(fifo_count), 32'd1);
      chk("ld_pending_hold", {31'd0, rs1_pending}, 32'd1);
      step();
      chk("ld_wb_en", {31'd0, wb_en}, 32'd1);
      chk("ld_rd_index", {27'd0, rd_index}, 32'd7);
      chk("ld_wb_data", wb_data, 32'h1234);
      chk("ld_pending_clear", {31'd0, rs1_pending}, 32'd0);

      // collision: ALU holds x3 for 4 cycles while x1, x2 responses arrive
      li = 0;
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h30 + 32'(i);
         ld_valid = (li < 2);
         ld_rd    = (li == 0) ? 5'd1 : 5'd2;
         ld_data  = (li == 0) ? 32'h11 : 32'h22;
         step();
         chk("col_alu_rd", {27'd0, rd_index}, 32'd3);
         if (m_acc) li++;
      end
      idle();
      chk("col_full_count", 32'(fifo_count), 32'd2);
      chk("col_full_ready", {31'd0, ld_ready}, 32'd0);
      step();
      chk("col_first_rd", {27'd0, rd_index}, 32'd1);
      chk("col_first_data", wb_data, 32'h11);
      step();
      chk("col_second_rd", {27'd0, rd_index}, 32'd2);
      chk("col_second_data", wb_data, 32'h22);
      step();
      chk("col_idle", {31'd0, wb_en}, 32'd0);

      // x0 suppression
      chk("x0_ready", {31'd0, ld_ready}, 32'd1);
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h99;
      issue_valid = 1'b1; issue_rd = 5'd0; rs1_index = 5'd0;
      step();
      idle();
      chk("x0_wb_en", {31'd0, wb_en}, 32'd0);
      chk("x0_count", 32'(fifo_count), 32'd0);
      chk("x0_pending", {31'd0, rs1_pending}, 32'd0);
      step();
      chk("x0_wb_en_after", {31'd0, wb_en}, 32'd0);

      // same-cycle set and clear on x9
      issue_valid = 1'b1; issue_rd = 5'd9; rs1_index = 5'd9;
      step();
      issue_valid = 1'b0; ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9999;
      step();
      ld_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9;
      step();
      idle();
      chk("sc_wb_rd", {27'd0, rd_index}, 32'd9);
      chk("sc_pending_kept", {31'd0, rs1_pending}, 32'd1);
      step();

      // reset mid-operation with a full FIFO and pending bits
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3;
      issue_valid = 1'b1; issue_rd = 5'd4; ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h44;
      step();
      issue_rd = 5'd5; ld_rd = 5'd5; ld_data = 32'h55;
      step();
      issue_valid = 1'b0; ld_valid = 1'b0;
      step();
      idle();
      rs1_index = 5'd4; rs2_index = 5'd5;
      chk("mr_count_full", 32'(fifo_count), 32'd2);
      chk("mr_pending_set", {31'd0, rs1_pending}, 32'd1);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("mr_wb_en", {31'd0, wb_en}, 32'd0);
      chk("mr_rd_index", {27'd0, rd_index}, 32'd0);
      chk("mr_wb_data", wb_data, 32'd0);
      chk("mr_count", 32'(fifo_count), 32'd0);
      chk("mr_ready", {31'd0, ld_ready}, 32'd0);
      chk("mr_rs1_pending", {31'd0, rs1_pending}, 32'd0);
      chk("mr_rs2_pending", {31'd0, rs2_pending}, 32'd0);
      step();
      rst = 1'b1;
      step(); step(); step();
      chk("mr_no_stale_write", {31'd0, wb_en}, 32'd0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         alu_valid   = ($urandom_range(0, 99) < ((i % 100) < 20 ? 95 : 35));
         alu_rd      = 5'($urandom_range(0, 31));
         alu_data    = $urandom;
         ld_valid    = ($urandom_range(0, 99) < 50);
         ld_rd       = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         ld_data     = $urandom;
         issue_valid = ($urandom_range(0, 99) < 30);
         issue_rd    = 5'($urandom_range(0, 31));
         rs1_index   = 5'($urandom_range(0, 31));
         rs2_index   = 5'($urandom_range(0, 31));
         step();
      end
      idle();
      for (int i = 0; i < 6; i++) step();
      @(negedge clk);
      #1;
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-side controller for the integer register file. It merges single-cycle ALU results with variable-latency load responses into the register file's single write port (`wb_en`, `rd_index`, `wb_data`). Load responses are held in a small FIFO, and the controller drives the write port from registered outputs. It also tracks which registers have loads still outstanding, so decode can stall on `rs1`/`rs2` read-after-write hazards.

## Interface
- `DEPTH`, default 2: load-response FIFO entries; power of two, at least 2.
- `clk`  in  1: single clock; everything is rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `alu_valid`  in  1: ALU result present this cycle. There is no ready; the ALU always wins.
- `alu_rd`  in  5: ALU destination register.
- `alu_data`  in  32: ALU result.
- `ld_valid`  in  1: load response offered.
- `ld_ready`  out  1: FIFO can accept a response.
- `ld_rd`  in  5: load destination register.
- `ld_data`  in  32: load data.
- `issue_valid`  in  1: a load is issued this cycle.
- `issue_rd`  in  5: destination register of the issued load.
- `rs1_index`, `rs2_index`  in  5 each: registers being read by decode.
- `rs1_pending`, `rs2_pending`  out  1 each: the indexed register has a load outstanding.
- `wb_en`  out  1: register-file write enable.
- `rd_index`  out  5: write destination.
- `wb_data`  out  32: write data.
- `fifo_count`  out  $clog2(DEPTH+1): current FIFO occupancy.

## Operation
- **Selection (combinational, every cycle):**
  - If `alu_valid` and `alu_rd != 0`, select the ALU result.
  - Otherwise, if the FIFO is non-empty, select the FIFO head and pop it.
  - Otherwise, select nothing.
- **Output register:** the selected write is registered into `wb_en`/`rd_index`/`wb_data`. When nothing is selected, `wb_en` = 0 and `rd_index`/`wb_data` hold their previous values.
- **x0 writes:**
  - An ALU result with `alu_rd == 0` is discarded; the FIFO may pop in that cycle.
  - A load response with `ld_rd == 0` is accepted (handshake completes) but not enqueued.
  - `wb_en` is never 1 with `rd_index == 0`.
- **Handshake:**
  - `ld_ready = (fifo_count < DEPTH)`, driven 0 while `rst` is low.
  - A transfer occurs on any edge where `ld_valid` and `ld_ready` are both 1.
  - `ld_ready` does not depend on a same-cycle pop, so a full FIFO never accepts.
- **FIFO:** circular buffer with read and write pointers that wrap modulo DEPTH. Push and pop in the same cycle leave `fifo_count` unchanged. Entries leave in order.
- **Pending scoreboard:** a 32-bit register; bit 0 is always 0.
  - Set on `issue_valid` when `issue_rd != 0`.
  - Cleared on the edge at which a FIFO pop of that rd commits.
  - If set and clear hit the same rd in the same cycle, set wins.
  - ALU writes do not affect pending bits; write-after-write ordering is the pipeline's responsibility.
  - `rs1_pending = pending[rs1_index]` and `rs2_pending = pending[rs2_index]`, both combinational from the register.
- **Starvation:** a continuous ALU stream starves the FIFO. Backpressure then comes only through `ld_ready`; this is the required behaviour.

## Timing
- **Reset (async, `rst` low):**
  - `wb_en` = 0, `rd_index` = 0, `wb_data` = 0.
  - FIFO pointers = 0, `fifo_count` = 0.
  - Pending vector = 0, so `rs1_pending` = `rs2_pending` = 0.
  - `ld_ready` = 0.
- **Reset deassertion:** `ld_ready` = 1 from the first cycle after.
- **Reset mid-operation:** FIFO contents and pending bits are dropped immediately; no write occurs afterwards for them.
- **ALU latency:** `alu_valid` in cycle N gives `wb_en` = 1 in cycle N+1.
- **Load latency:**
  - Minimum: accepted at the end of cycle N, head visible in cycle N+1, `wb_en` = 1 in cycle N+2.
  - Each cycle of ALU priority adds one cycle.
- **Pending clear:** the bit falls in the same cycle that `wb_en` goes high for that load. The register file therefore holds the data on the edge after decode sees pending = 0. The decode stage must account for this one-cycle gap, for example by forwarding `wb_data`.
- **Throughput:** at most one write per cycle; one load accepted per cycle while not full.

## Test plan
- **Basic ALU write:** reset, then `alu_valid` = 1, `alu_rd` = 5, `alu_data` = 0xDEADBEEF in cycle 1 -> cycle 2 shows `wb_en` = 1, `rd_index` = 5, `wb_data` = 0xDEADBEEF; cycle 3 shows `wb_en` = 0.
- **Load path and scoreboard:** issue load to x7 (`rs1_index` = 7 -> `rs1_pending` = 1 next cycle); response 0x1234 accepted at cycle 4 -> `wb_en`, `rd_index` = 7, `wb_data` = 0x1234 at cycle 6; `rs1_pending` = 0 at cycle 6.
- **Collision and full FIFO:** responses x1 = 0x11 and x2 = 0x22 arrive while `alu_valid` holds x3 for 4 cycles -> `ld_ready` = 0 after 2 accepts, `fifo_count` = 2; the x3 writes come first, then x1 and x2 in order once the ALU idles.
- **x0 suppression:** ALU to x0 plus a load response to x0 -> `wb_en` never 1; `ld_ready` handshake completes; `fifo_count` stays 0; `issue_rd` = 0 leaves `pending[0]` = 0.
- **Same-cycle set and clear:** the pop of x9 commits in the same cycle a new issue to x9 arrives -> `pending[9]` stays 1.
- **Reset mid-operation:** assert `rst` low asynchronously (between edges) with `fifo_count` = 2 and pending bits set -> all outputs go to their reset values immediately, and no stale write appears after release.
